level_controller: RTL and testbench



---
 rtl/level_pkg.sv | 37 +++
 rtl/second_tick.sv | 39 +++
 rtl/level_controller.sv | 173 +++++++++++++++++
 tb/tb_level_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// rtl/level_pkg.sv - shared types, default constants and speed clamp for the game sequencer
package level_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_LEVEL_UP  = 2'd2,
        ST_GAME_OVER = 2'd3
    } lvl_state_t;

    localparam int unsigned SPEED_W = 28;

    localparam logic [SPEED_W-1:0] DEF_BASE_SPEED = 28'd99_999_999;
    localparam logic [SPEED_W-1:0] DEF_SPEED_STEP = 28'd12_500_000;
    localparam logic [SPEED_W-1:0] DEF_MIN_SPEED  = 28'd12_499_999;

    // Speed for a level: base minus level*step, never below the floor.
    // The product is formed wider than 28 bits so an oversized step cannot
    // wrap, and the subtraction only happens when it cannot underflow.
    function automatic logic [SPEED_W-1:0] clamp_speed(
        input logic [2:0]         lvl,
        input logic [SPEED_W-1:0] base,
        input logic [SPEED_W-1:0] step,
        input logic [SPEED_W-1:0] floor_v
    );
        logic [30:0]        reduction;
        logic [SPEED_W-1:0] diff;
        reduction = {28'd0, lvl} * {3'd0, step};
        if (reduction >= {3'd0, base}) begin
            clamp_speed = floor_v;
        end else begin
            diff = base - reduction[SPEED_W-1:0];
            clamp_speed = (diff < floor_v) ? floor_v : diff;
        end
    endfunction

endpackage

// File: rtl/second_tick.sv
// rtl/second_tick.sv - one-second prescaler with synchronous clear and a single-cycle tick
module second_tick #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clock_i,
    input  logic resetn_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count down from CLK_HZ-1; reload on reaching zero or while cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick is the terminal count, suppressed while cleared so an idle
    // sequencer never sees a stray second.
    assign tick_o = !clr_i && (cnt_q == '0);

endmodule

// File: rtl/level_controller.sv
// rtl/level_controller.sv - whack-a-mole game sequencer: state, round timer, score and level
module level_controller
    import level_pkg::*;
#(
    parameter int unsigned  CLK_HZ         = 50_000_000,
    parameter int unsigned  GAME_SECONDS   = 60,
    parameter int unsigned  HITS_PER_LEVEL = 5,
    parameter int unsigned  MAX_LEVEL      = 7,
    parameter logic [27:0]  BASE_SPEED     = DEF_BASE_SPEED,
    parameter logic [27:0]  SPEED_STEP     = DEF_SPEED_STEP,
    parameter logic [27:0]  MIN_SPEED      = DEF_MIN_SPEED
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        hit,
    input  logic        miss,
    output logic        game,
    output logic [27:0] speed,
    output logic [2:0]  level,
    output logic [7:0]  score,
    output logic [6:0]  seconds_left,
    output logic        game_over,
    output logic        level_up
);

    localparam logic [6:0] SECS_INIT = 7'(GAME_SECONDS);
    localparam logic [4:0] HPL       = 5'(HITS_PER_LEVEL);
    localparam logic [2:0] LVL_MAX   = 3'(MAX_LEVEL);

    lvl_state_t  state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic [2:0]  level_q, level_d;
    logic [3:0]  hits_q, hits_d;
    logic [6:0]  secs_q, secs_d;
    logic [27:0] speed_q, speed_d;
    logic        game_q, game_d;
    logic        game_over_q, game_over_d;
    logic        level_up_q, level_up_d;

    logic        active;
    logic        tick;
    logic        final_tick;
    logic [4:0]  hits_inc;

    assign active = (state_q == ST_PLAY) || (state_q == ST_LEVEL_UP);

    second_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_second_tick (
        .clock_i  (clock),
        .resetn_i (resetn),
        .clr_i    (!active),
        .tick_o   (tick)
    );

    assign hits_inc = {1'b0, hits_q} + 5'd1;

    // Next-state logic: the final tick outranks a level advance, and a low
    // start switch outranks everything, returning to a fully cleared IDLE.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        level_d    = level_q;
        hits_d     = hits_q;
        secs_d     = secs_q;
        level_up_d = 1'b0;
        final_tick = 1'b0;

        case (state_q)
            ST_IDLE: begin
                score_d = 8'd0;
                level_d = 3'd0;
                hits_d  = 4'd0;
                secs_d  = SECS_INIT;
                if (start) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY, ST_LEVEL_UP: begin
                state_d = ST_PLAY;

                // Simultaneous hit and miss cancel on the score.
                if (hit && !miss && (score_q != 8'hFF)) begin
                    score_d = score_q + 8'd1;
                end else if (miss && !hit && (score_q != 8'd0)) begin
                    score_d = score_q - 8'd1;
                end

                final_tick = tick && (secs_q <= 7'd1);
                if (tick) begin
                    secs_d = final_tick ? 7'd0 : (secs_q - 7'd1);
                end

                if (final_tick) begin
                    state_d = ST_GAME_OVER;
                end else if (hit) begin
                    if (level_q < LVL_MAX) begin
                        if (hits_inc >= HPL) begin
                            level_d    = level_q + 3'd1;
                            hits_d     = 4'd0;
                            level_up_d = 1'b1;
                            state_d    = ST_LEVEL_UP;
                        end else begin
                            hits_d = hits_inc[3:0];
                        end
                    end else if ({1'b0, hits_q} < HPL) begin
                        hits_d = hits_inc[3:0];
                    end
                end
            end

            ST_GAME_OVER: begin
                state_d = ST_GAME_OVER;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!start) begin
            state_d    = ST_IDLE;
            score_d    = 8'd0;
            level_d    = 3'd0;
            hits_d     = 4'd0;
            secs_d     = SECS_INIT;
            level_up_d = 1'b0;
        end
    end

    // Registered output views derived from the next state and level.
    always_comb begin
        game_d      = (state_d == ST_PLAY) || (state_d == ST_LEVEL_UP);
        game_over_d = (state_d == ST_GAME_OVER);
        speed_d     = clamp_speed(level_d, BASE_SPEED, SPEED_STEP, MIN_SPEED);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            score_q     <= 8'd0;
            level_q     <= 3'd0;
            hits_q      <= 4'd0;
            secs_q      <= SECS_INIT;
            speed_q     <= BASE_SPEED;
            game_q      <= 1'b0;
            game_over_q <= 1'b0;
            level_up_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            level_q     <= level_d;
            hits_q      <= hits_d;
            secs_q      <= secs_d;
            speed_q     <= speed_d;
            game_q      <= game_d;
            game_over_q <= game_over_d;
            level_up_q  <= level_up_d;
        end
    end

    assign game         = game_q;
    assign speed        = speed_q;
    assign level        = level_q;
    assign score        = score_q;
    assign seconds_left = secs_q;
    assign game_over    = game_over_q;
    assign level_up     = level_up_q;

endmodule

// File: tb/tb_level_controller.sv
// tb/tb_level_controller.sv - directed table and sequence checks for the game sequencer
module tb_level_controller;

    localparam logic [27:0] BASE = 28'd99_999_999;
    localparam logic [27:0] MINS = 28'd12_499_999;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start, hit, miss;
    logic        game, game_over, level_up;
    logic [27:0] speed;
    logic [2:0]  level;
    logic [7:0]  score;
    logic [6:0]  seconds_left;

    logic        b_start, b_hit, b_miss;
    logic        b_game, b_game_over, b_level_up;
    logic [27:0] b_speed;
    logic [2:0]  b_level;
    logic [7:0]  b_score;
    logic [6:0]  b_seconds_left;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    level_controller #(
        .CLK_HZ(10), .GAME_SECONDS(3), .HITS_PER_LEVEL(2), .MAX_LEVEL(7)
    ) u_dut (
        .clock(clock), .resetn(resetn), .start(start), .hit(hit), .miss(miss),
        .game(game), .speed(speed), .level(level), .score(score),
        .seconds_left(seconds_left), .game_over(game_over), .level_up(level_up)
    );

    level_controller #(
        .CLK_HZ(100), .GAME_SECONDS(5), .HITS_PER_LEVEL(2), .MAX_LEVEL(7)
    ) u_dut_long (
        .clock(clock), .resetn(resetn), .start(b_start), .hit(b_hit), .miss(b_miss),
        .game(b_game), .speed(b_speed), .level(b_level), .score(b_score),
        .seconds_left(b_seconds_left), .game_over(b_game_over), .level_up(b_level_up)
    );

    typedef struct {
        logic        start, hit, miss;
        logic        game;
        logic [2:0]  level;
        logic [7:0]  score;
        logic [6:0]  secs;
        logic        lu;
        logic [27:0] speed;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic setv(input int i, input logic s, input logic h, input logic m,
                        input logic g, input logic [2:0] l, input logic [7:0] sc,
                        input logic [6:0] se, input logic u, input logic [27:0] sp);
        vecs[i].start = s; vecs[i].hit = h; vecs[i].miss = m;
        vecs[i].game = g; vecs[i].level = l; vecs[i].score = sc;
        vecs[i].secs = se; vecs[i].lu = u; vecs[i].speed = sp;
    endtask

    initial begin
        int k;
        int lu_cnt;
        int lu_extra;

        // inputs: start hit miss | expected: game level score secs level_up speed
        setv(0,  1, 0, 0, 1, 0, 0, 3, 0, BASE);
        setv(1,  1, 1, 0, 1, 0, 1, 3, 0, BASE);
        setv(2,  1, 1, 0, 1, 1, 2, 3, 1, 28'd87_499_999);
        setv(3,  1, 1, 0, 1, 1, 3, 3, 0, 28'd87_499_999);
        setv(4,  1, 1, 0, 1, 2, 4, 3, 1, 28'd74_999_999);
        setv(5,  1, 1, 1, 1, 2, 4, 3, 0, 28'd74_999_999);
        setv(6,  1, 1, 0, 1, 3, 5, 3, 1, 28'd62_499_999);
        setv(7,  1, 0, 1, 1, 3, 4, 3, 0, 28'd62_499_999);
        setv(8,  1, 0, 1, 1, 3, 3, 3, 0, 28'd62_499_999);
        setv(9,  1, 0, 1, 1, 3, 2, 3, 0, 28'd62_499_999);
        setv(10, 1, 0, 1, 1, 3, 1, 2, 0, 28'd62_499_999);
        setv(11, 1, 0, 1, 1, 3, 0, 2, 0, 28'd62_499_999);
        setv(12, 1, 0, 1, 1, 3, 0, 2, 0, 28'd62_499_999);

        resetn = 1'b0; start = 0; hit = 0; miss = 0;
        b_start = 0; b_hit = 0; b_miss = 0;
        repeat (2) cyc();
        chk("rst_game", game, 0);
        chk("rst_speed", speed, BASE);
        chk("rst_level", level, 0);
        chk("rst_score", score, 0);
        chk("rst_secs", seconds_left, 3);
        chk("rst_game_over", game_over, 0);
        chk("rst_level_up", level_up, 0);
        resetn = 1'b1;
        cyc();

        // Table: start, level advances, hit+miss cancel, miss floor, first tick
        for (int i = 0; i < 13; i++) begin
            start = vecs[i].start; hit = vecs[i].hit; miss = vecs[i].miss;
            cyc();
            chk($sformatf("vec%0d_game", i), game, vecs[i].game);
            chk($sformatf("vec%0d_level", i), level, vecs[i].level);
            chk($sformatf("vec%0d_score", i), score, vecs[i].score);
            chk($sformatf("vec%0d_secs", i), seconds_left, vecs[i].secs);
            chk($sformatf("vec%0d_level_up", i), level_up, vecs[i].lu);
            chk($sformatf("vec%0d_speed", i), speed, vecs[i].speed);
        end
        hit = 0; miss = 0;

        // Round timer from a fresh start to GAME_OVER
        start = 0; cyc();
        chk("abort_game", game, 0);
        chk("abort_secs", seconds_left, 3);
        start = 1; cyc();
        chk("timer_start_game", game, 1);
        for (k = 1; k <= 30; k++) begin
            cyc();
            if (k == 9)  chk("timer_k9_secs", seconds_left, 3);
            if (k == 10) chk("timer_k10_secs", seconds_left, 2);
            if (k == 20) chk("timer_k20_secs", seconds_left, 1);
            if (k == 29) begin
                chk("timer_k29_secs", seconds_left, 1);
                chk("timer_k29_game", game, 1);
            end
            if (k == 30) begin
                chk("timer_k30_secs", seconds_left, 0);
                chk("timer_k30_game_over", game_over, 1);
                chk("timer_k30_game", game, 0);
            end
        end
        hit = 1; cyc(); hit = 0;
        chk("over_hit_score", score, 0);
        chk("over_hold", game_over, 1);
        chk("over_secs", seconds_left, 0);
        start = 0; cyc();
        chk("over_exit_game_over", game_over, 0);
        chk("over_exit_secs", seconds_left, 3);

        // Climb to MAX_LEVEL, then no further pulses
        start = 1; cyc();
        hit = 1; lu_cnt = 0; lu_extra = 0;
        for (int j = 0; j < 16; j++) begin
            cyc();
            if (level_up) lu_cnt++;
        end
        chk("climb_level", level, 7);
        chk("climb_speed", speed, MINS);
        chk("climb_score", score, 16);
        chk("climb_pulses", lu_cnt, 7);
        for (int j = 0; j < 2; j++) begin
            cyc();
            if (level_up) lu_extra++;
        end
        hit = 0;
        chk("max_no_pulse", lu_extra, 0);
        chk("max_level_hold", level, 7);
        start = 0; cyc();

        // Abort mid-PLAY by the start switch
        start = 1; cyc();
        hit = 1; repeat (7) cyc(); hit = 0;
        chk("pre_abort_level", level, 3);
        chk("pre_abort_score", score, 7);
        start = 0; cyc();
        chk("sw_abort_game", game, 0);
        chk("sw_abort_score", score, 0);
        chk("sw_abort_level", level, 0);
        chk("sw_abort_speed", speed, BASE);

        // Asynchronous reset mid-PLAY
        start = 1; cyc();
        hit = 1; repeat (7) cyc(); hit = 0;
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_game", game, 0);
        chk("async_rst_score", score, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_speed", speed, BASE);
        chk("async_rst_secs", seconds_left, 3);
        start = 0;
        @(negedge clock) resetn = 1'b1;
        cyc();

        // Threshold hit on the final tick: score counts, no advance
        start = 1; cyc();
        hit = 1; cyc(); hit = 0;
        chk("ft_first_score", score, 1);
        for (k = 2; k <= 29; k++) cyc();
        chk("ft_pre_game", game, 1);
        hit = 1; cyc(); hit = 0;
        chk("ft_score", score, 2);
        chk("ft_level", level, 0);
        chk("ft_level_up", level_up, 0);
        chk("ft_game_over", game_over, 1);
        chk("ft_game", game, 0);
        hit = 1; cyc(); hit = 0;
        chk("ft_after_score", score, 2);
        chk("ft_after_level", level, 0);
        start = 0; cyc();

        // Score saturation at 255 on the long-round instance
        b_start = 1; cyc();
        b_hit = 1;
        repeat (255) cyc();
        chk("sat_255", b_score, 255);
        repeat (2) cyc();
        b_hit = 0;
        chk("sat_257", b_score, 255);
        chk("sat_game", b_game, 1);
        chk("sat_game_over", b_game_over, 0);
        chk("sat_level", b_level, 7);
        chk("sat_speed", b_speed, MINS);
        chk("sat_level_up", b_level_up, 0);
        chk("sat_secs", b_seconds_left, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
